// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command link: samples mid-bit, rejects start
// glitches, flags bad stop bits and holds each good byte with a sticky rdy.
module uart_cmd_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned HALF_DIV = 1302
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned BIT_W = 4;

  typedef enum logic {IDLE, RECV} state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [8:0]         shift_q, shift_d;
  logic               done_q, done_d;
  logic [7:0]         data_q, data_d;
  logic               rdy_q, rdy_d;
  logic               frm_q, frm_d;

  // Two-flop synchronizer, preset high so reset release never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      frm_q   <= frm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    data_d  = data_q;
    rdy_d   = rdy_q;
    frm_d   = 1'b0;

    if (clr_rdy) rdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          baud_d  = CNT_W'(HALF_DIV - 1);
          bit_d   = '0;
          rdy_d   = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (baud_q == '0) begin
          shift_d = {rx_s_q, shift_q[8:1]};
          bit_d   = bit_q + BIT_W'(1);
          baud_d  = CNT_W'(BAUD_DIV - 1);
          if (bit_q == '0 && rx_s_q) begin
            state_d = IDLE;
          end else if (bit_q == BIT_W'(9)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame completion is applied one clock after the stop sample; set beats clear
    if (done_q) begin
      if (shift_q[8]) begin
        data_d = shift_q[7:0];
        rdy_d  = 1'b1;
      end else begin
        frm_d = 1'b1;
      end
    end
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed + random bench for uart_cmd_rx with a bit-level transmitter model
// and an event monitor that logs every rdy rise and frm_err pulse.
module tb_uart_cmd_rx;

  localparam int unsigned B = 64;
  localparam int unsigned H = 32;
  localparam int unsigned LAT = H + 9 * B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [7:0] got_q[$];
  int         rdy_cyc_q[$];
  logic [7:0] exp_q[$];
  int         frm_rise = 0;
  int         frm_hi = 0;
  logic       rdy_p = 1'b0;
  logic       frm_p = 1'b0;

  uart_cmd_rx #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rdy_p <= rdy;
    frm_p <= frm_err;
    if (rdy === 1'b1 && rdy_p !== 1'b1) begin
      got_q.push_back(rx_data);
      rdy_cyc_q.push_back(cyc);
    end
    if (frm_err === 1'b1) frm_hi <= frm_hi + 1;
    if (frm_err === 1'b1 && frm_p !== 1'b1) frm_rise <= frm_rise + 1;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is always positioned just after a negedge
  task automatic tx_frame(input logic [7:0] d, input logic stop);
    RX = 1'b0;
    start_cyc = cyc;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * B) @(negedge clk);
  endtask

  task automatic ack_n(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (rdy !== 1'b1 && t < 12 * B) begin
        @(negedge clk);
        t++;
      end
      check("ack_seen", 32'(rdy), 32'd1);
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    rdy_cyc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    logic [7:0] r;
    logic [7:0] v3c;
    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle line
    idle_bits(16);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_frm", 32'(frm_rise), 32'd0);
    check("reset_data", 32'(rx_data), 32'h00);
    check("idle_no_rdy", 32'(got_q.size()), 32'd0);

    // First byte and its latency from the start edge
    tx_frame(8'h67, 1'b1);
    idle_bits(2);
    lat = (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - start_cyc : -1;
    check("latency_window", 32'(lat >= int'(LAT) + 2 && lat <= int'(LAT) + 5), 32'd1);
    check("rdy_held", 32'(rdy), 32'd1);
    exp_q.push_back(8'h67);
    compare_stream("first");

    // New start edge clears rdy without clr_rdy; old data still visible
    fork
      tx_frame(8'h73, 1'b1);
      begin
        repeat (10) @(negedge clk);
        check("start_clears_rdy", 32'(rdy), 32'd0);
        check("data_kept_in_frame", 32'(rx_data), 32'h67);
      end
    join
    idle_bits(2);
    exp_q.push_back(8'h73);
    compare_stream("reload");
    check("rdy_after_73", 32'(rdy), 32'd1);

    // clr_rdy clears rdy, data stays
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    check("clr_rdy", 32'(rdy), 32'd0);
    check("clr_keeps_data", 32'(rx_data), 32'h73);
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    check("clr_when_low", 32'(rdy), 32'd0);

    // Back-to-back frames, zero idle bits
    fork
      begin
        tx_frame(8'h67, 1'b1);
        tx_frame(8'h73, 1'b1);
        tx_frame(8'h00, 1'b1);
        tx_frame(8'hFF, 1'b1);
        idle_bits(2);
      end
      ack_n(4);
    join
    exp_q = '{8'h67, 8'h73, 8'h00, 8'hFF};
    compare_stream("b2b");

    // Short low pulse is rejected as a glitch
    RX = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(12);
    check("glitch_no_rdy", 32'(got_q.size()), 32'd0);
    check("glitch_no_frm", 32'(frm_rise), 32'd0);
    tx_frame(8'hA5, 1'b1);
    idle_bits(2);
    exp_q.push_back(8'hA5);
    compare_stream("post_glitch");
    ack_n(1);

    // Bad stop bit
    tx_frame(8'h55, 1'b0);
    idle_bits(12);
    check("frm_err_events", 32'(frm_rise), 32'd1);
    check("frm_err_width", 32'(frm_hi), 32'd1);
    check("frm_no_rdy", 32'(rdy), 32'd0);
    check("frm_data_kept", 32'(rx_data), 32'hA5);
    compare_stream("bad_stop");

    // Reset during bit 4 of 8'h3C; the transmitter is reset with the system
    v3c = 8'h3C;
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = v3c[i];
      repeat (B) @(negedge clk);
    end
    RX = v3c[4];
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(12);
    check("midreset_rdy", 32'(rdy), 32'd0);
    check("midreset_data", 32'(rx_data), 32'h00);
    check("midreset_frm", 32'(frm_rise), 32'd1);
    compare_stream("midreset");

    // Next frame with clr_rdy held high: set wins on the set clock
    clr_rdy = 1'b1;
    tx_frame(8'hC3, 1'b1);
    idle_bits(2);
    clr_rdy = 1'b0;
    check("setwins_data", 32'(rx_data), 32'hC3);
    check("setwins_then_clear", 32'(rdy), 32'd0);
    exp_q.push_back(8'hC3);
    compare_stream("setwins");

    // Random bytes with random idle gaps against the queue model
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          r = 8'($urandom);
          exp_q.push_back(r);
          tx_frame(r, 1'b1);
          idle_bits(int'($urandom_range(0, 2)));
        end
        idle_bits(2);
      end
      ack_n(8);
    join
    compare_stream("random");
    check("random_no_frm", 32'(frm_rise), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
